// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a time
// on the instruction bus and buffers returned words in a small FIFO for decode.
// A redirect flushes the buffer and restarts fetch. A response that was already
// requested when the redirect arrived is drained and dropped.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'hbfc0_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic        out_exc_adel
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD, S_HALT} state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } entry_t;

    state_e         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    req_pc_q, req_pc_d;
    logic           stale_q, stale_d;
    entry_t         mem_q [FIFO_DEPTH];
    entry_t         mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           misaligned, pop, push, slot_idle, slot_wait;
    logic [CW-1:0]  cnt_after_pop;
    entry_t         push_entry, head;

    // Slot accounting: a request is only launched when the word it returns is
    // guaranteed a free entry, so the in-flight request always owns one slot.
    always_comb begin
        misaligned    = (pc_q[1:0] != 2'b00);
        pop           = (count_q != '0) && out_ready && !redirect_valid;
        cnt_after_pop = count_q - CW'(pop);
        slot_idle     = (cnt_after_pop < DEPTH_C);
        slot_wait     = ((cnt_after_pop + CW'(1)) < DEPTH_C);
    end

    // Next-state logic; redirect outranks every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                // A misaligned PC also waits for a free entry to hold its exception.
                if (!redirect_valid && slot_idle)
                    state_d = misaligned ? S_HALT : S_REQ;
            end
            S_REQ: begin
                if (iresp_addr_ok)
                    state_d = (redirect_valid || stale_q) ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (iresp_data_ok) begin
                    if (!redirect_valid && slot_wait && !misaligned)
                        state_d = S_REQ;
                    else
                        state_d = S_IDLE;
                end else if (redirect_valid) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (iresp_data_ok)
                    state_d = S_IDLE;
            end
            S_HALT: begin
                if (redirect_valid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PC, request address, stale flag and FIFO bookkeeping.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        stale_d    = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (redirect_valid)
            pc_d = redirect_pc;
        else if (state_q == S_REQ && iresp_addr_ok && !stale_q)
            pc_d = pc_q + 32'd4;

        if ((state_q == S_IDLE || state_q == S_WAIT) && state_d == S_REQ)
            req_pc_d = pc_q;

        // A request that cannot be withdrawn keeps its address but remembers
        // that its response belongs to the pre-redirect stream.
        if (state_q == S_REQ && !iresp_addr_ok)
            stale_d = stale_q || redirect_valid;

        if (!redirect_valid) begin
            if (state_q == S_IDLE && slot_idle && misaligned) begin
                push       = 1'b1;
                push_entry = '{instr: 32'd0, pc: pc_q, adel: 1'b1};
            end else if (state_q == S_WAIT && iresp_data_ok) begin
                push       = 1'b1;
                push_entry = '{instr: iresp_data, pc: req_pc_q, adel: 1'b0};
            end
        end

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = cnt_after_pop + CW'(push);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            stale_q  <= 1'b0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            stale_q  <= stale_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Bus request and decode-side outputs; decode fields read zero when empty.
    always_comb begin
        ireq_valid   = (state_q == S_REQ);
        ireq_addr    = req_pc_q;
        head         = mem_q[rd_ptr_q];
        out_valid    = (count_q != '0);
        out_instr    = '0;
        out_pc       = '0;
        out_pcplus4  = '0;
        out_exc_adel = 1'b0;
        if (out_valid) begin
            out_instr    = head.instr;
            out_pc       = head.pc;
            out_pcplus4  = head.pc + 32'd4;
            out_exc_adel = head.adel;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a bus responder with programmable address/data latency,
// an address scoreboard checked at each accepted request, and an output
// scoreboard popped by a monitor on every decoder handshake.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok = 1'b0;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_pc, out_pcplus4;
    logic        out_exc_adel;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr[$];
    int          checks = 0;
    int          errors = 0;
    int          addr_delay = 0;
    int          data_delay = 1;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pcplus4   (out_pcplus4),
        .out_exc_adel  (out_exc_adel)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_out(input logic [31:0] pc, input logic adel);
        exp_t e;
        e.pc    = pc;
        e.adel  = adel;
        e.instr = adel ? 32'd0 : ~pc;
        exp_q.push_back(e);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    // sel 0: ireq_valid, sel 1: out_valid; returns as soon as it is seen
    task automatic wait_for(input int sel, input string nm);
        for (int i = 0; i < 200; i++) begin
            if ((sel == 0 && ireq_valid) || (sel == 1 && out_valid)) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for valid", nm);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout, %0d outputs still expected", nm, exp_q.size());
        exp_q.delete();
    endtask

    task automatic quiesce();
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        exp_addr.delete();
    endtask

    // Bus responder: accepts after addr_delay cycles of ireq_valid, returns
    // data (~addr) data_delay cycles after acceptance.
    initial begin
        bit          pend = 0, have = 0;
        int          acnt = 0, dcnt = 0;
        logic [31:0] paddr = '0, held = '0;
        forever begin
            @(negedge clk);
            iresp_addr_ok = 1'b0;
            iresp_data_ok = 1'b0;
            if (!resetn) begin
                pend = 0; have = 0; acnt = 0;
            end else begin
                if (pend) begin
                    if (dcnt == 0) begin
                        iresp_data_ok = 1'b1;
                        iresp_data    = ~paddr;
                        pend          = 0;
                    end else dcnt--;
                end
                if (ireq_valid) begin
                    if (have) chk("ireq_addr_hold", ireq_addr, held);
                    else begin held = ireq_addr; have = 1; end
                    if (acnt >= addr_delay) begin
                        iresp_addr_ok = 1'b1;
                        pend  = 1;
                        paddr = ireq_addr;
                        dcnt  = data_delay - 1;
                        acnt  = 0;
                        have  = 0;
                        if (exp_addr.size() > 0) chk("ireq_addr", ireq_addr, exp_addr.pop_front());
                    end else acnt++;
                end
            end
        end
    end

    // Output monitor: every decoder handshake must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual_pc=%h expected=none", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_instr", out_instr, e.instr);
                    chk("out_pc", out_pc, e.pc);
                    chk("out_pcplus4", out_pcplus4, e.pc + 32'd4);
                    chk("out_exc_adel", {31'd0, out_exc_adel}, {31'd0, e.adel});
                end
            end
        end
    end

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ireq_valid", {31'd0, ireq_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pcplus4", out_pcplus4, 32'd0);

        // 1: sequential fetch from the reset vector
        addr_delay = 0; data_delay = 1;
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'hbfc0_0000 + 32'(4 * i));
            push_out(32'hbfc0_0000 + 32'(4 * i), 1'b0);
        end
        out_ready = 1'b1;
        resetn    = 1'b1;
        drain("t1_seq");
        quiesce();

        // 2: backpressure fills exactly two entries, head holds
        exp_addr.push_back(32'h0000_1000);
        exp_addr.push_back(32'h0000_1004);
        redirect(32'h0000_1000);
        repeat (20) @(posedge clk);
        #1;
        chk("t2_addrs_issued", 32'(exp_addr.size()), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("t2_no_req", {31'd0, ireq_valid}, 32'd0);
            chk("t2_head_pc", out_pc, 32'h0000_1000);
            chk("t2_head_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        exp_addr.push_back(32'h0000_1008);
        exp_addr.push_back(32'h0000_100c);
        push_out(32'h0000_1000, 1'b0);
        push_out(32'h0000_1004, 1'b0);
        push_out(32'h0000_1008, 1'b0);
        push_out(32'h0000_100c, 1'b0);
        out_ready = 1'b1;
        drain("t2_resume");
        quiesce();

        // 3: redirect while waiting for data (3-cycle data latency)
        data_delay = 3;
        exp_addr.push_back(32'h0000_2000);
        exp_addr.push_back(32'h8000_0100);
        redirect(32'h0000_2000);
        wait_for(0, "t3_req");
        @(posedge clk); #1;
        redirect(32'h8000_0100);
        chk("t3_flush_empty", {31'd0, out_valid}, 32'd0);
        push_out(32'h8000_0100, 1'b0);
        push_out(32'h8000_0104, 1'b0);
        out_ready = 1'b1;
        drain("t3_redirect_wait");
        quiesce();

        // 4: redirect while the request is held (addr_ok 2 cycles late)
        addr_delay = 2; data_delay = 1;
        exp_addr.push_back(32'h0000_3000);
        exp_addr.push_back(32'h8000_0200);
        redirect(32'h0000_3000);
        wait_for(0, "t4_req");
        redirect(32'h8000_0200);
        chk("t4_stale_addr", ireq_addr, 32'h0000_3000);
        push_out(32'h8000_0200, 1'b0);
        push_out(32'h8000_0204, 1'b0);
        out_ready = 1'b1;
        drain("t4_redirect_req");
        quiesce();

        // 5: misaligned redirect target raises an exception entry and halts
        addr_delay = 0;
        redirect(32'h8000_0102);
        chk("t5_flush_full", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t5_no_req", {31'd0, ireq_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("t5_adel_valid", {31'd0, out_valid}, 32'd1);
        push_out(32'h8000_0102, 1'b1);
        out_ready = 1'b1;
        drain("t5_adel");
        for (int i = 0; i < 5; i++) begin
            chk("t5_halt_req", {31'd0, ireq_valid}, 32'd0);
            chk("t5_halt_out", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        quiesce();

        // pc wraps through 2^32
        exp_addr.push_back(32'hffff_fffc);
        exp_addr.push_back(32'h0000_0000);
        push_out(32'hffff_fffc, 1'b0);
        push_out(32'h0000_0000, 1'b0);
        redirect(32'hffff_fffc);
        out_ready = 1'b1;
        drain("t_wrap");
        quiesce();

        // 6: reset with a response outstanding
        data_delay = 3;
        redirect(32'h0000_4000);
        wait_for(1, "t6_first_word");
        wait_for(0, "t6_second_req");
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("t6_rst_ireq_valid", {31'd0, ireq_valid}, 32'd0);
        chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        exp_addr.delete();
        exp_addr.push_back(32'hbfc0_0000);
        push_out(32'hbfc0_0000, 1'b0);
        out_ready = 1'b1;
        resetn    = 1'b1;
        drain("t6_after_reset");
        out_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
